pce_bram_sync: RTL and testbench



---
 rtl/pce_bram_pkg.sv | 17 +
 rtl/pce_bram_sync.sv | 194 +++++++++++++++++++
 tb/tb_pce_bram_sync.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pce_bram_pkg.sv
// rtl/pce_bram_pkg.sv - shared types and constants for the backup-RAM sequencer
package pce_bram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FMT  = 3'd1,
    ST_WAIT = 3'd2,
    ST_REQ  = 3'd3,
    ST_XFER = 3'd4
  } bram_state_e;

  localparam int BRAM_SECTORS = 16;

  // "HUBM" signature plus the empty-directory pointers the console expects
  localparam logic [15:0] BRAM_HDR [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

endpackage

// File: rtl/pce_bram_sync.sv
// rtl/pce_bram_sync.sv - backup-RAM save/load/format sequencer between hps_io and RAM port B
module pce_bram_sync
  import pce_bram_pkg::*;
#(
  parameter int SECTORS = BRAM_SECTORS
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        downloading,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic        bk_load,
  input  logic        bk_save,
  input  logic        format,
  input  logic        cd_busy,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        sd_own,
  output logic [11:0] ram_addr,
  output logic [15:0] ram_din,
  output logic        ram_we,
  output logic        bk_ena,
  output logic        bk_loading,
  output logic        bk_busy
);

  localparam logic [3:0] LBA_LAST = 4'(SECTORS - 1);

  bram_state_e state_q, state_d;
  logic [1:0]  fmt_cnt_q, fmt_cnt_d;
  logic [3:0]  lba_q, lba_d;
  logic        loading_q, loading_d;
  logic        own_q, own_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        ena_q, ena_d;

  logic        dl_q, fmt_q, load_q, save_q, ack_q;
  logic        dl_rise, dl_fall, fmt_rise, load_rise, save_rise, ack_rise, ack_fall;

  assign dl_rise   = downloading & ~dl_q;
  assign dl_fall   = ~downloading & dl_q;
  assign fmt_rise  = format & ~fmt_q;
  assign load_rise = bk_load & ~load_q;
  assign save_rise = bk_save & ~save_q;
  assign ack_rise  = sd_ack & ~ack_q;
  assign ack_fall  = ~sd_ack & ack_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q   <= 1'b0;
      fmt_q  <= 1'b0;
      load_q <= 1'b0;
      save_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      dl_q   <= downloading;
      fmt_q  <= format;
      load_q <= bk_load;
      save_q <= bk_save;
      ack_q  <= sd_ack;
    end
  end

  always_comb begin
    state_d   = state_q;
    fmt_cnt_d = fmt_cnt_q;
    lba_d     = lba_q;
    loading_d = loading_q;
    own_d     = own_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    ena_d     = ena_q;

    // A mount seen during the download overrides the clear at its start
    if (dl_rise) ena_d = 1'b0;
    if (downloading && img_mounted && !img_readonly) ena_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (fmt_rise) begin
          state_d   = ST_FMT;
          fmt_cnt_d = 2'd0;
          lba_d     = 4'd0;
        end else if (dl_fall && ena_q && (img_size != 64'd0)) begin
          state_d   = ST_WAIT;
          loading_d = 1'b1;
          lba_d     = 4'd0;
        end else if (load_rise && ena_q) begin
          state_d   = ST_WAIT;
          loading_d = 1'b1;
          lba_d     = 4'd0;
        end else if (save_rise && ena_q) begin
          state_d   = ST_WAIT;
          loading_d = 1'b0;
          lba_d     = 4'd0;
        end
      end
      ST_FMT: begin
        fmt_cnt_d = fmt_cnt_q + 2'd1;
        if (fmt_cnt_q == 2'd3) state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (!cd_busy) begin
          state_d = ST_REQ;
          own_d   = 1'b1;
          rd_d    = loading_q;
          wr_d    = ~loading_q;
        end
      end
      ST_REQ: begin
        if (ack_rise) begin
          state_d = ST_XFER;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      ST_XFER: begin
        if (ack_fall) begin
          if (lba_q == LBA_LAST) begin
            state_d   = ST_IDLE;
            loading_d = 1'b0;
            own_d     = 1'b0;
          end else begin
            state_d = ST_WAIT;
            lba_d   = lba_q + 4'd1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        loading_d = 1'b0;
        own_d     = 1'b0;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      fmt_cnt_q <= 2'd0;
      lba_q     <= 4'd0;
      loading_q <= 1'b0;
      own_q     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ena_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fmt_cnt_q <= fmt_cnt_d;
      lba_q     <= lba_d;
      loading_q <= loading_d;
      own_q     <= own_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ena_q     <= ena_d;
    end
  end

  // Load data goes straight through so the RAM captures on the sd_buff_wr edge
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = 12'd0;
    ram_din  = 16'd0;
    if (state_q == ST_FMT) begin
      ram_we   = 1'b1;
      ram_addr = {10'd0, fmt_cnt_q};
      ram_din  = BRAM_HDR[fmt_cnt_q];
    end else if (state_q == ST_XFER) begin
      ram_addr = {lba_q, sd_buff_addr};
      if (loading_q) begin
        ram_we  = sd_buff_wr & sd_ack;
        ram_din = sd_buff_dout;
      end
    end
  end

  assign sd_lba     = {28'd0, lba_q};
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign sd_own     = own_q;
  assign bk_ena     = ena_q;
  assign bk_loading = loading_q;
  assign bk_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pce_bram_sync.sv
// tb/tb_pce_bram_sync.sv - self-checking bench for pce_bram_sync
module tb_pce_bram_sync;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        downloading = 1'b0;
  logic        img_mounted = 1'b0;
  logic        img_readonly = 1'b0;
  logic [63:0] img_size = 64'd0;
  logic        bk_load = 1'b0;
  logic        bk_save = 1'b0;
  logic        format = 1'b0;
  logic        cd_busy = 1'b0;
  logic        sd_ack = 1'b0;
  logic [7:0]  sd_buff_addr = 8'd0;
  logic [15:0] sd_buff_dout = 16'd0;
  logic        sd_buff_wr = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_own;
  logic [11:0] ram_addr;
  logic [15:0] ram_din;
  logic        ram_we, bk_ena, bk_loading, bk_busy;

  pce_bram_sync #(.SECTORS(16)) dut (
    .clk_sys(clk_sys), .reset(reset), .downloading(downloading),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .bk_load(bk_load), .bk_save(bk_save), .format(format), .cd_busy(cd_busy),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_own(sd_own), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .bk_ena(bk_ena), .bk_loading(bk_loading), .bk_busy(bk_busy)
  );

  always #5 clk_sys = ~clk_sys;

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Reference RAM image built from the words the bench hands out, and the image the DUT actually wrote
  logic [15:0] exp_mem [4096];
  logic [15:0] shadow  [4096];
  int we_cnt = 0;
  int sd_act_cnt = 0;
  int both_cnt = 0;
  int busy_cnt = 0;

  always @(negedge clk_sys) begin
    if (ram_we) begin
      shadow[ram_addr] = ram_din;
      we_cnt++;
    end
    if (sd_rd || sd_wr || sd_own) sd_act_cnt++;
    if (sd_rd && sd_wr) both_cnt++;
    if (bk_busy) busy_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic mount(input bit ro, input logic [63:0] size);
    tick();
    downloading = 1'b1;
    repeat (3) tick();
    img_mounted = 1'b1;
    img_readonly = ro;
    img_size = size;
    tick();
    img_mounted = 1'b0;
    repeat (3) tick();
    downloading = 1'b0;
  endtask

  // Plays the HPS side of one sector; nwords < 256 leaves sd_ack high mid-transfer
  task automatic serve_sector(input bit load, input int nwords, output logic [31:0] lba,
                              output bit rd, output bit wr, output int gap,
                              output bit hold, output bit tmo);
    int n;
    logic [11:0] idx;
    logic [15:0] d;
    n = 0; tmo = 1'b0; hold = 1'b0; rd = 1'b0; wr = 1'b0; lba = 32'd0;
    @(negedge clk_sys);
    while (!(sd_rd || sd_wr) && n < 2000) begin
      n++;
      @(negedge clk_sys);
    end
    gap = n;
    if (!(sd_rd || sd_wr)) begin
      tmo = 1'b1;
      return;
    end
    lba = sd_lba; rd = sd_rd; wr = sd_wr;
    tick();
    sd_ack = 1'b1;
    repeat (2) tick();
    if (sd_rd || sd_wr) hold = 1'b1;
    for (int a = 0; a < nwords; a++) begin
      sd_buff_addr = 8'(a);
      if (load) begin
        d = 16'($urandom);
        sd_buff_dout = d;
        sd_buff_wr = 1'b1;
        idx = {lba[3:0], 8'(a)};
        exp_mem[idx] = d;
      end
      tick();
    end
    sd_buff_wr = 1'b0;
    if (nwords >= 256) sd_ack = 1'b0;
  endtask

  task automatic run_sectors(input bit load, input int first, input int count,
                             output int lba_err, output int dir_err, output int gap_err,
                             output int hold_err, output int tmo_cnt);
    logic [31:0] lba;
    bit rd, wr, hold, tmo;
    int gap;
    lba_err = 0; dir_err = 0; gap_err = 0; hold_err = 0; tmo_cnt = 0;
    for (int i = 0; i < count; i++) begin
      serve_sector(load, 256, lba, rd, wr, gap, hold, tmo);
      if (tmo) begin
        tmo_cnt++;
        break;
      end
      if (lba != 32'(first + i)) lba_err++;
      if (rd !== load || wr !== !load) dir_err++;
      if (i > 0 && gap < 2) gap_err++;
      if (hold) hold_err++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk_sys);
    chk_cnt++;
    if ({sd_lba, sd_rd, sd_wr, sd_own, ram_addr, ram_din, ram_we, bk_ena, bk_loading, bk_busy} !== 67'd0)
      $display("FAIL reset_outputs: got lba=%h rd=%b wr=%b own=%b addr=%h din=%h we=%b ena=%b ld=%b busy=%b, required all 0",
               sd_lba, sd_rd, sd_wr, sd_own, ram_addr, ram_din, ram_we, bk_ena, bk_loading, bk_busy);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk_cnt++;
    if ({sd_rd, sd_wr, sd_own, ram_we, bk_busy} !== 5'd0)
      $display("FAIL post_reset_idle: got rd=%b wr=%b own=%b we=%b busy=%b, required 0",
               sd_rd, sd_wr, sd_own, ram_we, bk_busy);
    else pass_cnt++;
  endtask

  task automatic test_format();
    logic [15:0] hdr [4];
    logic [11:0] got_addr [8];
    logic [15:0] got_data [8];
    int nw, nb, ns, bad;
    hdr = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};
    nw = 0; nb = 0; ns = 0; bad = 0;
    format = 1'b1;
    tick();
    format = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_sys);
      if (ram_we && nw < 8) begin
        got_addr[nw] = ram_addr;
        got_data[nw] = ram_din;
        nw++;
      end
      if (bk_busy) nb++;
      if (sd_rd || sd_wr || sd_own) ns++;
    end
    chk_cnt++;
    if (nw != 4) $display("FAIL fmt_we_count: got %0d, required 4", nw);
    else pass_cnt++;
    for (int k = 0; k < 4 && k < nw; k++) begin
      chk_cnt++;
      if (got_addr[k] !== 12'(k) || got_data[k] !== hdr[k]) begin
        bad++;
        $display("FAIL fmt_word%0d: got addr=%h data=%h, required addr=%h data=%h",
                 k, got_addr[k], got_data[k], 12'(k), hdr[k]);
      end else pass_cnt++;
    end
    chk_cnt++;
    if (nb != 4) $display("FAIL fmt_busy_cycles: got %0d, required 4", nb);
    else pass_cnt++;
    chk_cnt++;
    if (ns != 0) $display("FAIL fmt_sd_quiet: got %0d active cycles, required 0", ns);
    else pass_cnt++;
  endtask

  task automatic test_autoload();
    int le, de, ge, he, te, mism, w0;
    mount(1'b0, 64'd8192);
    chk_cnt++;
    if (bk_ena !== 1'b1) $display("FAIL autoload_ena: got %b, required 1", bk_ena);
    else pass_cnt++;
    w0 = we_cnt;
    repeat (2) @(negedge clk_sys);
    chk_cnt++;
    if (bk_loading !== 1'b1 || bk_busy !== 1'b1)
      $display("FAIL autoload_start: got loading=%b busy=%b, required 1 1", bk_loading, bk_busy);
    else pass_cnt++;
    run_sectors(1'b1, 0, 16, le, de, ge, he, te);
    chk_cnt++;
    if (te != 0 || le != 0 || de != 0)
      $display("FAIL autoload_sectors: got timeouts=%0d lba_err=%0d dir_err=%0d, required 0 0 0", te, le, de);
    else pass_cnt++;
    chk_cnt++;
    if (ge != 0 || he != 0)
      $display("FAIL autoload_handshake: got gap_err=%0d hold_err=%0d, required 0 0", ge, he);
    else pass_cnt++;
    repeat (3) tick();
    chk_cnt++;
    if (bk_loading !== 1'b0 || bk_busy !== 1'b0 || sd_own !== 1'b0)
      $display("FAIL autoload_end: got loading=%b busy=%b own=%b, required 0 0 0", bk_loading, bk_busy, sd_own);
    else pass_cnt++;
    chk_cnt++;
    if (we_cnt - w0 != 4096) $display("FAIL autoload_we_count: got %0d, required 4096", we_cnt - w0);
    else pass_cnt++;
    mism = 0;
    for (int i = 0; i < 4096; i++) if (shadow[i] !== exp_mem[i]) mism++;
    chk_cnt++;
    if (mism != 0) $display("FAIL autoload_ram_image: got %0d mismatching words, required 0", mism);
    else pass_cnt++;
  endtask

  task automatic test_save_cd_busy();
    int le, de, ge, he, te, s0, w0, early;
    cd_busy = 1'b1;
    tick();
    bk_save = 1'b1;
    tick();
    bk_save = 1'b0;
    early = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_sys);
      if (sd_wr || sd_rd || sd_own) early++;
    end
    chk_cnt++;
    if (early != 0 || bk_busy !== 1'b1 || bk_loading !== 1'b0)
      $display("FAIL save_cd_hold: got sd_cycles=%0d busy=%b loading=%b, required 0 1 0", early, bk_busy, bk_loading);
    else pass_cnt++;
    w0 = we_cnt;
    s0 = sd_act_cnt;
    tick();
    cd_busy = 1'b0;
    run_sectors(1'b0, 0, 16, le, de, ge, he, te);
    chk_cnt++;
    if (te != 0 || le != 0 || de != 0 || ge != 0 || he != 0)
      $display("FAIL save_sectors: got tmo=%0d lba=%0d dir=%0d gap=%0d hold=%0d, required all 0", te, le, de, ge, he);
    else pass_cnt++;
    repeat (3) tick();
    chk_cnt++;
    if (we_cnt != w0) $display("FAIL save_no_ram_we: got %0d writes, required 0", we_cnt - w0);
    else pass_cnt++;
    chk_cnt++;
    if (bk_busy !== 1'b0 || sd_act_cnt == s0)
      $display("FAIL save_end: got busy=%b sd_cycles=%0d, required busy 0 and nonzero SD activity", bk_busy, sd_act_cnt - s0);
    else pass_cnt++;
  endtask

  task automatic test_format_beats_load();
    int w0, s0;
    w0 = we_cnt;
    s0 = sd_act_cnt;
    format = 1'b1;
    bk_load = 1'b1;
    tick();
    format = 1'b0;
    bk_load = 1'b0;
    repeat (12) tick();
    chk_cnt++;
    if (we_cnt - w0 != 4 || sd_act_cnt != s0 || bk_busy !== 1'b0)
      $display("FAIL format_priority: got writes=%0d sd_cycles=%0d busy=%b, required 4 0 0",
               we_cnt - w0, sd_act_cnt - s0, bk_busy);
    else pass_cnt++;
  endtask

  task automatic test_readonly();
    int s0, b0;
    mount(1'b1, 64'd8192);
    repeat (3) tick();
    chk_cnt++;
    if (bk_ena !== 1'b0) $display("FAIL ro_ena: got %b, required 0", bk_ena);
    else pass_cnt++;
    s0 = sd_act_cnt;
    b0 = busy_cnt;
    bk_load = 1'b1;
    tick();
    bk_load = 1'b0;
    tick();
    bk_save = 1'b1;
    tick();
    bk_save = 1'b0;
    repeat (30) tick();
    chk_cnt++;
    if (sd_act_cnt != s0 || busy_cnt != b0)
      $display("FAIL ro_ignored: got sd_cycles=%0d busy_cycles=%0d, required 0 0", sd_act_cnt - s0, busy_cnt - b0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    int le, de, ge, he, te, mism;
    logic [31:0] lba;
    bit rd, wr, hold, tmo;
    int gap;
    mount(1'b0, 64'd0);
    repeat (3) tick();
    chk_cnt++;
    if (bk_ena !== 1'b1 || bk_busy !== 1'b0)
      $display("FAIL rml_mount: got ena=%b busy=%b, required 1 0", bk_ena, bk_busy);
    else pass_cnt++;
    bk_load = 1'b1;
    tick();
    bk_load = 1'b0;
    run_sectors(1'b1, 0, 5, le, de, ge, he, te);
    serve_sector(1'b1, 100, lba, rd, wr, gap, hold, tmo);
    chk_cnt++;
    if (te != 0 || le != 0 || tmo || lba !== 32'd5 || rd !== 1'b1)
      $display("FAIL rml_reach_sector5: got tmo=%0d/%b lba_err=%0d lba=%0d rd=%b, required 0/0 0 5 1",
               te, tmo, le, lba, rd);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    chk_cnt++;
    if ({sd_lba, sd_rd, sd_wr, sd_own, ram_addr, ram_din, ram_we, bk_ena, bk_loading, bk_busy} !== 67'd0)
      $display("FAIL rml_reset_outputs: got lba=%h own=%b addr=%h din=%h we=%b ena=%b ld=%b busy=%b, required all 0",
               sd_lba, sd_own, ram_addr, ram_din, ram_we, bk_ena, bk_loading, bk_busy);
    else pass_cnt++;
    sd_ack = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    mount(1'b0, 64'd0);
    repeat (3) tick();
    bk_load = 1'b1;
    tick();
    bk_load = 1'b0;
    run_sectors(1'b1, 0, 16, le, de, ge, he, te);
    chk_cnt++;
    if (te != 0 || le != 0 || de != 0 || ge != 0 || he != 0)
      $display("FAIL rml_reload: got tmo=%0d lba=%0d dir=%0d gap=%0d hold=%0d, required all 0", te, le, de, ge, he);
    else pass_cnt++;
    repeat (3) tick();
    mism = 0;
    for (int i = 0; i < 4096; i++) if (shadow[i] !== exp_mem[i]) mism++;
    chk_cnt++;
    if (mism != 0 || bk_loading !== 1'b0)
      $display("FAIL rml_ram_image: got %0d mismatching words loading=%b, required 0 0", mism, bk_loading);
    else pass_cnt++;
    chk_cnt++;
    if (both_cnt != 0) $display("FAIL rd_wr_exclusive: got %0d cycles with both, required 0", both_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_format();
    test_autoload();
    test_save_cd_busy();
    test_format_beats_load();
    test_readonly();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
